// File: rtl/dog_stream.sv
// rtl/dog_stream.sv - Difference-of-Gaussians stage: four blurred pixel streams in, three biased DoG planes out.
// Counts one N*M frame, drains the two-stage pipeline, then pulses done for one cycle.
module dog_stream #(
  parameter int          N    = 450,
  parameter int          M    = 600,
  parameter int          DW   = 8,
  parameter logic [15:0] BIAS = 16'h8000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          data_valid,
  input  logic [DW-1:0] G0,
  input  logic [DW-1:0] G1,
  input  logic [DW-1:0] G2,
  input  logic [DW-1:0] G3,
  output logic [15:0]   Diff1,
  output logic [15:0]   Diff2,
  output logic [15:0]   Diff3,
  output logic          output_valid,
  output logic          done,
  output logic          overrun,
  output logic [19:0]   pix_count
);

  localparam logic [19:0] FRAME_PIX = 20'(N * M);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] pix_count_q, pix_count_d;
  logic        overrun_q, overrun_d;
  logic        done_q, done_d;
  logic        accept;
  logic [19:0] pix_next;

  logic        s1_valid_q, s1_valid_d;
  logic [15:0] s1_g0_q, s1_g0_d;
  logic [15:0] s1_g1_q, s1_g1_d;
  logic [15:0] s1_g2_q, s1_g2_d;
  logic [15:0] s1_g3_q, s1_g3_d;

  logic        s2_valid_q, s2_valid_d;
  logic [15:0] diff1_q, diff1_d;
  logic [15:0] diff2_q, diff2_d;
  logic [15:0] diff3_q, diff3_d;

  assign pix_next = pix_count_q + 20'd1;

  always_comb begin
    state_d     = state_q;
    pix_count_d = pix_count_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          accept      = 1'b1;
          overrun_d   = 1'b0;
          pix_count_d = 20'd1;
          state_d     = (FRAME_PIX == 20'd1) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (data_valid) begin
          accept      = 1'b1;
          pix_count_d = pix_next;
          if (pix_next == FRAME_PIX) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (data_valid) begin
          overrun_d = 1'b1;
        end
        // Nothing enters stage 1 here, so an empty stage 1 behind a full stage 2 means the last pixel is on the outputs.
        if (s2_valid_q && !s1_valid_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (data_valid) begin
          overrun_d = 1'b1;
        end
        pix_count_d = 20'd0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s1_valid_d = accept;
    s1_g0_d    = s1_g0_q;
    s1_g1_d    = s1_g1_q;
    s1_g2_d    = s1_g2_q;
    s1_g3_d    = s1_g3_q;
    if (accept) begin
      s1_g0_d = {{(16-DW){1'b0}}, G0};
      s1_g1_d = {{(16-DW){1'b0}}, G1};
      s1_g2_d = {{(16-DW){1'b0}}, G2};
      s1_g3_d = {{(16-DW){1'b0}}, G3};
    end
  end

  // Differences wrap mod 2^16; with DW <= 15 the biased result never aliases.
  always_comb begin
    s2_valid_d = s1_valid_q;
    diff1_d    = diff1_q;
    diff2_d    = diff2_q;
    diff3_d    = diff3_q;
    if (s1_valid_q) begin
      diff1_d = s1_g1_q - s1_g0_q + BIAS;
      diff2_d = s1_g2_q - s1_g1_q + BIAS;
      diff3_d = s1_g3_q - s1_g2_q + BIAS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pix_count_q <= 20'd0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_g0_q     <= 16'h0000;
      s1_g1_q     <= 16'h0000;
      s1_g2_q     <= 16'h0000;
      s1_g3_q     <= 16'h0000;
      s2_valid_q  <= 1'b0;
      diff1_q     <= 16'h0000;
      diff2_q     <= 16'h0000;
      diff3_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pix_count_q <= pix_count_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_g0_q     <= s1_g0_d;
      s1_g1_q     <= s1_g1_d;
      s1_g2_q     <= s1_g2_d;
      s1_g3_q     <= s1_g3_d;
      s2_valid_q  <= s2_valid_d;
      diff1_q     <= diff1_d;
      diff2_q     <= diff2_d;
      diff3_q     <= diff3_d;
    end
  end

  assign Diff1        = diff1_q;
  assign Diff2        = diff2_q;
  assign Diff3        = diff3_q;
  assign output_valid = s2_valid_q;
  assign done         = done_q;
  assign overrun      = overrun_q;
  assign pix_count    = pix_count_q;

endmodule
